// File: rtl/spike_window_accumulator.sv
// spike_window_accumulator
//   Counts 1-bit spike events per channel over a counting window and latches
//   the per-channel totals into a result register. The window is closed either
//   after WINDOW_LEN enabled cycles (internal mode) or by win_strobe (external
//   mode). The result leaves through a valid/ready handshake. It carries
//   per-channel saturation flags and a sticky overrun flag.
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high; clears all state and any pending result
//   en          count enable; spikes ignored and internal window held when 0
//   ext_mode    0 = internal WINDOW_LEN window, 1 = window closed by win_strobe
//   win_strobe  external window close (ext_mode=1 only, independent of en)
//   spike_in    one spike bit per channel
//   out_ready   consumer accepts the result
//   out_valid   result register holds an unconsumed result
//   out_count   channel c count at [c*ACC_DATA_WIDTH +: ACC_DATA_WIDTH]
//   out_sat     channel count saturated in this result
//   overrun     sticky: an unconsumed result was overwritten
module spike_window_accumulator #(
    parameter int NUM_CH         = 4,
    parameter int ACC_DATA_WIDTH = 16,
    parameter int WINDOW_LEN     = 256
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             ext_mode,
    input  logic                             win_strobe,
    input  logic [NUM_CH-1:0]                spike_in,
    input  logic                             out_ready,
    output logic                             out_valid,
    output logic [NUM_CH*ACC_DATA_WIDTH-1:0] out_count,
    output logic [NUM_CH-1:0]                out_sat,
    output logic                             overrun
);

    localparam int W     = ACC_DATA_WIDTH;
    localparam int CNT_W = $clog2(WINDOW_LEN);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_LEN - 1);

    // Saturating increment: an all-ones count holds instead of wrapping.
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] a, input logic inc);
        if (inc && (a != '1)) begin
            return a + W'(1);
        end
        return a;
    endfunction

    // A spike arriving at an already-full count marks the channel saturated.
    function automatic logic sat_hit(input logic [W-1:0] a, input logic inc);
        return inc && (a == '1);
    endfunction

    logic [W-1:0]      acc_p0 [NUM_CH];
    logic [NUM_CH-1:0] sat_p0;
    logic [CNT_W-1:0]  win_cnt;

    logic [W-1:0]      acc_sum_p0 [NUM_CH];
    logic [NUM_CH-1:0] sat_sum_p0;
    logic              close_p0;

    // Stage 0: accumulator state plus this cycle's spike, and the close decision.
    // The closing cycle's spike is folded into the sum so it lands in the
    // closing window's result.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            acc_sum_p0[c] = sat_inc(acc_p0[c], en & spike_in[c]);
            sat_sum_p0[c] = sat_p0[c] | sat_hit(acc_p0[c], en & spike_in[c]);
        end
        if (ext_mode) begin
            close_p0 = win_strobe;
        end else begin
            close_p0 = en && (win_cnt == WIN_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_p0[c] <= '0;
            end
            sat_p0 <= '0;
        end else if (close_p0) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_p0[c] <= '0;
            end
            sat_p0 <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_p0[c] <= acc_sum_p0[c];
            end
            sat_p0 <= sat_sum_p0;
        end
    end

    // Window counter is parked at 0 in external mode so switching back to
    // internal mode always starts a full window.
    always_ff @(posedge clk) begin
        if (reset || ext_mode) begin
            win_cnt <= '0;
        end else if (en) begin
            if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + CNT_W'(1);
            end
        end
    end

    // Stage 1: result register with valid/ready handshake. A close always
    // loads; overrun only when the pending result was neither consumed nor
    // being consumed on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_sat   <= '0;
            overrun   <= 1'b0;
        end else if (close_p0) begin
            out_valid <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                out_count[c*W +: W] <= acc_sum_p0[c];
            end
            out_sat <= sat_sum_p0;
            if (out_valid && !out_ready) begin
                overrun <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_window_accumulator.sv
module tb_spike_window_accumulator;

    localparam int NC   = 4;
    localparam int W    = 4;
    localparam int WL   = 20;
    localparam int MAXC = (1 << W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              en = 1'b0;
    logic              ext_mode = 1'b0;
    logic              win_strobe = 1'b0;
    logic [NC-1:0]     spike_in = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [NC*W-1:0]   out_count;
    logic [NC-1:0]     out_sat;
    logic              overrun;

    spike_window_accumulator #(
        .NUM_CH(NC), .ACC_DATA_WIDTH(W), .WINDOW_LEN(WL)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .ext_mode(ext_mode),
        .win_strobe(win_strobe), .spike_in(spike_in), .out_ready(out_ready),
        .out_valid(out_valid), .out_count(out_count), .out_sat(out_sat),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC*W-1:0] cnt;
        logic [NC-1:0]   sat;
    } res_t;

    res_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   started = 0;

    // Reference model: unbounded spike tally per channel and a count of enabled
    // cycles in the current internal window. Results are clipped at report time.
    int   tally [NC];
    int   win_pos = 0;
    bit   exp_valid = 0, exp_ovr = 0;
    bit   cur_valid = 0, cur_ovr = 0;

    task automatic step(input bit r, input bit e, input bit x, input bit s,
                        input logic [NC-1:0] sp, input bit rdy);
        res_t res;
        bit   close;
        @(posedge clk);
        #1;
        reset = r; en = e; ext_mode = x; win_strobe = s; spike_in = sp; out_ready = rdy;
        cur_valid = exp_valid;
        cur_ovr   = exp_ovr;
        if (r) begin
            for (int c = 0; c < NC; c++) tally[c] = 0;
            win_pos = 0; exp_valid = 0; exp_ovr = 0;
            q.delete();
        end else begin
            if (e) for (int c = 0; c < NC; c++) tally[c] += int'(sp[c]);
            close = x ? s : (e && win_pos == WL - 1);
            if (x) win_pos = 0;
            else if (e) win_pos = (win_pos + 1) % WL;
            if (close) begin
                for (int c = 0; c < NC; c++) begin
                    res.cnt[c*W +: W] = W'((tally[c] > MAXC) ? MAXC : tally[c]);
                    res.sat[c]        = (tally[c] > MAXC);
                    tally[c] = 0;
                end
                if (exp_valid && !rdy && q.size() > 0) begin
                    exp_ovr = 1;
                    q[q.size()-1] = res;
                end else begin
                    q.push_back(res);
                end
                exp_valid = 1;
            end else if (exp_valid && rdy) begin
                exp_valid = 0;
            end
        end
    endtask

    task automatic check_zero(input string name);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_count !== '0 || out_sat !== '0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: valid=%b count=%h sat=%b overrun=%b, required all zero",
                     name, out_valid, out_count, out_sat, overrun);
        end
    endtask

    // Monitor: flags every cycle, result contents on each handshake.
    always @(negedge clk) begin
        if (started) begin
            vectors++;
            if (out_valid !== cur_valid) begin
                miscompares++;
                $display("FAIL out_valid @%0t: got %b, required %b", $time, out_valid, cur_valid);
            end
            vectors++;
            if (overrun !== cur_ovr) begin
                miscompares++;
                $display("FAIL overrun @%0t: got %b, required %b", $time, overrun, cur_ovr);
            end
            if (cur_valid && out_ready && !reset) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL result @%0t: no expected result queued", $time);
                end else begin
                    res_t e;
                    e = q.pop_front();
                    if (out_count !== e.cnt || out_sat !== e.sat) begin
                        miscompares++;
                        $display("FAIL result @%0t: count=%h sat=%b, required count=%h sat=%b",
                                 $time, out_count, out_sat, e.cnt, e.sat);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit x;
        for (int c = 0; c < NC; c++) tally[c] = 0;

        // Reset state
        step(1, 0, 0, 0, '0, 0);
        step(0, 0, 0, 0, '0, 0);
        started = 1;
        check_zero("reset_state");

        // Internal mode, channels 0 and 2 spiking every cycle
        for (int i = 0; i < 3*WL; i++) step(0, 1, 0, 0, 4'b0101, 1);

        // Internal mode saturation on channel 0
        for (int i = 0; i < 2*WL + 5; i++) step(0, 1, 0, 0, 4'b0001, 1);

        // Enable toggling: disabled cycles do not advance the window
        for (int i = 0; i < 4*WL + 4; i++) step(0, 1'(i % 2 == 0), 0, 0, 4'b1111, 1);

        // External mode: 5-cycle window including the strobe, then 1-cycle window
        step(0, 0, 1, 0, '0, 1);
        for (int i = 1; i <= 6; i++) step(0, 1, 1, 1'(i >= 5), 4'b1111, 1);
        step(0, 0, 1, 1, 4'b1111, 1);            // strobe with en=0 adds nothing
        for (int i = 0; i < 18; i++) step(0, 1, 1, 0, 4'b1011, 1);
        step(0, 1, 1, 1, 4'b1011, 1);            // saturating external window
        step(0, 0, 1, 0, '0, 1);

        // Overrun: two closes with no consumer
        step(0, 1, 1, 0, 4'b0011, 0);
        step(0, 1, 1, 1, 4'b0011, 0);
        step(0, 1, 1, 0, 4'b0110, 0);
        step(0, 1, 1, 1, 4'b0110, 0);
        step(0, 0, 1, 0, '0, 0);
        step(0, 0, 1, 0, '0, 1);

        // Close coincident with a handshake does not set overrun
        step(1, 0, 1, 0, '0, 0);
        step(0, 1, 1, 1, 4'b1000, 0);
        step(0, 1, 1, 0, 4'b1100, 0);
        step(0, 1, 1, 1, 4'b1100, 1);
        step(0, 0, 1, 0, '0, 1);

        // Reset mid-window with a pending result and 3 accumulated spikes
        step(0, 0, 0, 0, '0, 0);
        for (int i = 0; i < WL + 3; i++) step(0, 1, 0, 0, 4'b1111, 0);
        step(1, 1, 0, 0, 4'b1111, 0);
        step(0, 1, 0, 0, 4'b0001, 1);
        check_zero("mid_window_reset");
        for (int i = 0; i < WL + 2; i++) step(0, 1, 0, 0, 4'b0001, 1);

        // Randomized traffic; mode changes only while disabled
        x = 0;
        for (int i = 0; i < 900; i++) begin
            if (i % 150 == 149) begin
                x = !x;
                step(0, 0, x, 0, '0, 1'($urandom % 2));
            end else begin
                step(1'($urandom % 250 == 0), 1'($urandom % 4 != 0), x,
                     x ? 1'($urandom % 6 == 0) : 1'($urandom % 2),
                     NC'($urandom), 1'($urandom % 2));
            end
        end
        step(0, 0, x, 0, '0, 1);
        step(0, 0, x, 0, '0, 1);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
